// File: rtl/imm_encoder_if.sv
// Request/response bus for imm_encoder.
//   master : request producer / response consumer (drives in_*, fields, flush, out_ready)
//   slave  : the encoder (drives in_ready, out_valid, instr, out_err, err_count)
// Format select encodings (`I_TYPE .. `J_TYPE) are provided here when not already
// supplied by def_select.v; any other imm_sel value is an illegal format.

`ifndef I_TYPE
`define I_TYPE 3'd0
`endif
`ifndef S_TYPE
`define S_TYPE 3'd1
`endif
`ifndef B_TYPE
`define B_TYPE 3'd2
`endif
`ifndef U_TYPE
`define U_TYPE 3'd3
`endif
`ifndef J_TYPE
`define J_TYPE 3'd4
`endif

interface imm_encoder_if #(
    parameter int unsigned ERR_CNT_W = 16
);
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           imm_sel;
    logic [6:0]           opcode;
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [2:0]           funct3;
    logic [31:0]          imm;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          instr;
    logic                 out_err;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output flush, in_valid, imm_sel, opcode, rd, rs1, rs2, funct3, imm, out_ready,
        input  in_ready, out_valid, instr, out_err, err_count
    );

    modport slave (
        input  flush, in_valid, imm_sel, opcode, rd, rs1, rs2, funct3, imm, out_ready,
        output in_ready, out_valid, instr, out_err, err_count
    );
endinterface

// File: rtl/imm_encoder.sv
// imm_encoder: packs opcode, register fields, funct3 and a 32-bit immediate into an
// RV32I I/S/B/U/J instruction word through a two-stage valid/ready pipeline.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : imm_encoder_if.slave (flush, request fields + handshake,
//                packed instr / out_err / err_count + handshake)
// Stage A registers the request and its error flag; stage B holds the packed word.
// Optional feature: define IMM_RANGE_CHECK_EN to flag immediates that do not fit
// the selected format (the word is still packed by truncation).

module imm_encoder #(
    parameter int unsigned ERR_CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    imm_encoder_if.slave bus
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned OP_W  = 7;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned SEL_W = 3;

    // Stage A
    logic             a_valid;
    logic [SEL_W-1:0] a_sel;
    logic [OP_W-1:0]  a_op;
    logic [REG_W-1:0] a_rd;
    logic [REG_W-1:0] a_rs1;
    logic [REG_W-1:0] a_rs2;
    logic [F3_W-1:0]  a_f3;
    logic [XLEN-1:0]  a_imm;
    logic             a_err;

    // Stage B
    logic             b_valid;
    logic [XLEN-1:0]  b_instr;
    logic             b_err;
    logic [ERR_CNT_W-1:0] err_cnt;

    logic             b_adv_c;
    logic             in_ready_c;
    logic             accept_c;
    logic             cap_err_c;
    logic [XLEN-1:0]  pack_c;

    assign b_adv_c    = !b_valid || bus.out_ready;
    assign in_ready_c = !a_valid || b_adv_c;
    assign accept_c   = bus.in_valid && in_ready_c;

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = b_valid;
    assign bus.instr     = b_instr;
    assign bus.out_err   = b_err;
    assign bus.err_count = err_cnt;

    // Error flag for the incoming request; illegal formats (incl. X/Z selects) fall to default.
    always_comb begin
        cap_err_c = 1'b0;
        case (bus.imm_sel)
`ifdef IMM_RANGE_CHECK_EN
            `I_TYPE, `S_TYPE: cap_err_c = (bus.imm[31:11] != {21{bus.imm[11]}});
            `B_TYPE: cap_err_c = (bus.imm[31:12] != {20{bus.imm[12]}}) || bus.imm[0];
            `J_TYPE: cap_err_c = (bus.imm[31:20] != {12{bus.imm[20]}}) || bus.imm[0];
            `U_TYPE: cap_err_c = (bus.imm[11:0] != 12'h000);
`else
            `I_TYPE, `S_TYPE, `B_TYPE, `U_TYPE, `J_TYPE: cap_err_c = 1'b0;
`endif
            default: cap_err_c = 1'b1;
        endcase
    end

    // Instruction packing from stage A contents.
    always_comb begin
        pack_c = '0;
        case (a_sel)
            `I_TYPE: pack_c = {a_imm[11:0], a_rs1, a_f3, a_rd, a_op};
            `S_TYPE: pack_c = {a_imm[11:5], a_rs2, a_rs1, a_f3, a_imm[4:0], a_op};
            `B_TYPE: pack_c = {a_imm[12], a_imm[10:5], a_rs2, a_rs1, a_f3,
                               a_imm[4:1], a_imm[11], a_op};
            `U_TYPE: pack_c = {a_imm[31:12], a_rd, a_op};
            `J_TYPE: pack_c = {a_imm[20], a_imm[10:1], a_imm[11], a_imm[19:12], a_rd, a_op};
            default: pack_c = '0;
        endcase
    end

    // Stage A register: loads whenever it can accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid <= 1'b0;
            a_sel   <= '0;
            a_op    <= '0;
            a_rd    <= '0;
            a_rs1   <= '0;
            a_rs2   <= '0;
            a_f3    <= '0;
            a_imm   <= '0;
            a_err   <= 1'b0;
        end else if (bus.flush) begin
            a_valid <= 1'b0;
        end else if (in_ready_c) begin
            a_valid <= bus.in_valid;
            if (accept_c) begin
                a_sel <= bus.imm_sel;
                a_op  <= bus.opcode;
                a_rd  <= bus.rd;
                a_rs1 <= bus.rs1;
                a_rs2 <= bus.rs2;
                a_f3  <= bus.funct3;
                a_imm <= bus.imm;
                a_err <= cap_err_c;
            end
        end
    end

    // Stage B register: holds instr/out_err stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_valid <= 1'b0;
            b_instr <= '0;
            b_err   <= 1'b0;
        end else if (bus.flush) begin
            b_valid <= 1'b0;
        end else if (b_adv_c) begin
            b_valid <= a_valid;
            if (a_valid) begin
                b_instr <= pack_c;
                b_err   <= a_err;
            end
        end
    end

    // Saturating count of emitted error words; a flushed cycle completes no handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (!bus.flush && b_valid && bus.out_ready && b_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: scoreboard queue of expected words pushed on
// request accept and popped on each output handshake.

`ifndef I_TYPE
`define I_TYPE 3'd0
`endif
`ifndef S_TYPE
`define S_TYPE 3'd1
`endif
`ifndef B_TYPE
`define B_TYPE 3'd2
`endif
`ifndef U_TYPE
`define U_TYPE 3'd3
`endif
`ifndef J_TYPE
`define J_TYPE 3'd4
`endif

module tb_imm_encoder;

    localparam int unsigned ERR_CNT_W = 16;

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    logic clk;
    logic rst_n;

    imm_encoder_if #(.ERR_CNT_W(ERR_CNT_W)) bus ();

    imm_encoder #(.ERR_CNT_W(ERR_CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned n_out    = 0;
    exp_t        sb[$];
    exp_t        pending;
    logic        accepted;
    logic        bp_en    = 1'b0;
    logic [ERR_CNT_W-1:0] err_model = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference packing, written bit-by-bit from the RV32I encodings.
    function automatic logic [31:0] mdl_instr(input logic [2:0] sel, input logic [6:0] op,
                                              input logic [4:0] rd, input logic [4:0] rs1,
                                              input logic [4:0] rs2, input logic [2:0] f3,
                                              input logic [31:0] imm);
        logic [31:0] w;
        w = 32'h0;
        if (sel == `I_TYPE || sel == `S_TYPE || sel == `B_TYPE ||
            sel == `U_TYPE || sel == `J_TYPE) begin
            w[6:0] = op;
            if (sel == `I_TYPE || sel == `U_TYPE || sel == `J_TYPE) w[11:7] = rd;
            if (sel != `U_TYPE && sel != `J_TYPE) w[14:12] = f3;
            if (sel != `U_TYPE && sel != `J_TYPE) w[19:15] = rs1;
            if (sel == `S_TYPE || sel == `B_TYPE) w[24:20] = rs2;
            if (sel == `I_TYPE) w[31:20] = imm[11:0];
            if (sel == `S_TYPE) begin
                w[31:25] = imm[11:5];
                w[11:7]  = imm[4:0];
            end
            if (sel == `B_TYPE) begin
                w[31]    = imm[12];
                w[30:25] = imm[10:5];
                w[11:8]  = imm[4:1];
                w[7]     = imm[11];
            end
            if (sel == `U_TYPE) w[31:12] = imm[31:12];
            if (sel == `J_TYPE) begin
                w[31]    = imm[20];
                w[30:21] = imm[10:1];
                w[20]    = imm[11];
                w[19:12] = imm[19:12];
            end
        end
        return w;
    endfunction

    function automatic logic mdl_err(input logic [2:0] sel, input logic [31:0] imm);
        int signed v;
        v = int'($signed(imm));
        if (!(sel == `I_TYPE || sel == `S_TYPE || sel == `B_TYPE ||
              sel == `U_TYPE || sel == `J_TYPE)) return 1'b1;
`ifdef IMM_RANGE_CHECK_EN
        if (sel == `I_TYPE || sel == `S_TYPE) return (v < -2048 || v > 2047);
        if (sel == `B_TYPE) return (v < -4096 || v > 4095 || imm[0]);
        if (sel == `J_TYPE) return (v < -1048576 || v > 1048575 || imm[0]);
        return (imm[11:0] != 12'h0);
`else
        return (v != v);
`endif
    endfunction

    // One clock cycle: entered just after a falling edge with inputs already driven.
    task automatic tick();
        exp_t e;
        if (bp_en) bus.out_ready = 1'($urandom_range(0, 1));
        #1;
        accepted = 1'b0;
        if (bus.flush) begin
            sb.delete();
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(pending);
                accepted = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("instr", bus.instr, e.instr);
                    chk("out_err", 32'(bus.out_err), 32'(e.err));
                    if (e.err && err_model != '1) err_model = err_model + ERR_CNT_W'(1);
                    n_out++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [2:0] sel, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [31:0] imm, input logic [31:0] exp_i, input logic exp_e);
        bus.in_valid = 1'b1;
        bus.imm_sel  = sel;
        bus.opcode   = op;
        bus.rd       = rd;
        bus.rs1      = rs1;
        bus.rs2      = rs2;
        bus.funct3   = f3;
        bus.imm      = imm;
        pending.instr = exp_i;
        pending.err   = exp_e;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (accepted) break;
        end
        chk("accept", 32'(accepted), 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_m(input logic [2:0] sel, input logic [6:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                          input logic [31:0] imm);
        send(sel, op, rd, rs1, rs2, f3, imm, mdl_instr(sel, op, rd, rs1, rs2, f3, imm),
             mdl_err(sel, imm));
    endtask

    task automatic drain();
        bp_en         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
        tick();
        chk("drain_left", 32'(sb.size()), 32'd0);
        chk("err_count", 32'(bus.err_count), 32'(err_model));
    endtask

    logic        exp_err_i2048;
    logic        exp_err_b3;
    logic [31:0] w1_exp;
    int unsigned lat;
    int unsigned n0;
    logic [31:0] rimm;
    logic [2:0]  rsel;

    initial begin
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.imm_sel   = `I_TYPE;
        bus.opcode    = '0;
        bus.rd        = '0;
        bus.rs1       = '0;
        bus.rs2       = '0;
        bus.funct3    = '0;
        bus.imm       = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_out_err", 32'(bus.out_err), 32'd0);
        chk("rst_err_count", 32'(bus.err_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed encodings with latency check on the first word.
        send(`I_TYPE, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 32'd5, 32'h00500093, 1'b0);
        lat = 1;
        chk("lat_a", 32'(bus.out_valid), 32'd0);
        while (!bus.out_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk("latency", lat, 32'd2);
        send(`S_TYPE, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 32'd8, 32'h0020A423, 1'b0);
        send(`B_TYPE, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0);
        send(`J_TYPE, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 32'd8, 32'h008000EF, 1'b0);
        send(`U_TYPE, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 32'h12345000, 32'h123452B7, 1'b0);
        send(3'b111, 7'b0010011, 5'd1, 5'd2, 5'd3, 3'b001, 32'd5, 32'h00000000, 1'b1);
        drain();

        // Range checking (build dependent).
`ifdef IMM_RANGE_CHECK_EN
        exp_err_i2048 = 1'b1;
        exp_err_b3    = 1'b1;
`else
        exp_err_i2048 = 1'b0;
        exp_err_b3    = 1'b0;
`endif
        send(`I_TYPE, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 32'd2048, 32'h80000093, exp_err_i2048);
        send(`B_TYPE, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 32'd6, 32'h00000363, 1'b0);
        send(`B_TYPE, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 32'd3, 32'h00000163, exp_err_b3);
        drain();

        // Back-to-back burst against a 3-cycle stall.
        n0 = n_out;
        bus.out_ready = 1'b0;
        w1_exp = mdl_instr(`I_TYPE, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 32'd16);
        send_m(`I_TYPE, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 32'd16);
        send_m(`I_TYPE, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'b000, 32'd32);
        bus.in_valid = 1'b1;
        bus.rd       = 5'd3;
        bus.imm      = 32'd48;
        pending.instr = mdl_instr(`I_TYPE, 7'b0010011, 5'd3, 5'd0, 5'd0, 3'b000, 32'd48);
        pending.err   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_instr", bus.instr, w1_exp);
            tick();
        end
        bus.out_ready = 1'b1;
        send_m(`I_TYPE, 7'b0010011, 5'd3, 5'd0, 5'd0, 3'b000, 32'd48);
        send_m(`I_TYPE, 7'b0010011, 5'd4, 5'd0, 5'd0, 3'b000, 32'd64);
        drain();
        chk("burst_count", n_out - n0, 32'd4);

        // Flush with two words in flight.
        bus.out_ready = 1'b0;
        send_m(`U_TYPE, 7'b0110111, 5'd7, 5'd0, 5'd0, 3'b000, 32'hABCDE000);
        send_m(3'b101, 7'b0110111, 5'd7, 5'd0, 5'd0, 3'b000, 32'h0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        drain();

        // Randomised traffic with random backpressure.
        bp_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            rsel = ($urandom_range(0, 7) == 0) ? 3'(5 + $urandom_range(0, 2))
                                               : 3'($urandom_range(0, 4));
            rimm = $urandom;
            if ($urandom_range(0, 1) == 1) rimm = {{20{rimm[11]}}, rimm[11:0]};
            if ($urandom_range(0, 3) == 0) rimm[0] = 1'b0;
            send_m(rsel, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                   3'($urandom), rimm);
        end
        drain();

        // Asynchronous reset in the middle of a burst.
        bus.out_ready = 1'b0;
        send_m(`J_TYPE, 7'b1101111, 5'd2, 5'd0, 5'd0, 3'b000, 32'd100);
        send_m(`I_TYPE, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'b000, 32'd4096);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("arst_instr", bus.instr, 32'd0);
        chk("arst_out_err", 32'(bus.out_err), 32'd0);
        chk("arst_err_count", 32'(bus.err_count), 32'd0);
        sb.delete();
        err_model = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_m(`S_TYPE, 7'b0100011, 5'd0, 5'd3, 5'd4, 3'b010, 32'hFFFFF800);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
